// File: rtl/flag_condition_unit_pkg.sv
// Shared definitions for the flag condition unit.
// Flag bit positions, condition codes and FSM states.
package flag_condition_unit_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] CC_AL = 4'h0;
  localparam logic [3:0] CC_EQ = 4'h1;
  localparam logic [3:0] CC_NE = 4'h2;
  localparam logic [3:0] CC_CS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_MI = 4'h5;
  localparam logic [3:0] CC_PL = 4'h6;
  localparam logic [3:0] CC_VS = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;
  localparam logic [3:0] CC_HI = 4'h9;
  localparam logic [3:0] CC_LS = 4'hA;
  localparam logic [3:0] CC_GE = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GT = 4'hD;
  localparam logic [3:0] CC_LE = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/flag_condition_unit_cond_eval.sv
// Combinational condition evaluator: (Flags, Cond) -> Pass.
// Ports: Flags {N,Z,C,V}, Cond code, Pass result.
module flag_condition_unit_cond_eval
  import flag_condition_unit_pkg::*;
(
  input  logic [3:0] Flags,
  input  logic [3:0] Cond,
  output logic       Pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    Pass = 1'b0;
    unique case (Cond)
      CC_AL: Pass = 1'b1;
      CC_EQ: Pass = z;
      CC_NE: Pass = ~z;
      CC_CS: Pass = c;
      CC_CC: Pass = ~c;
      CC_MI: Pass = n;
      CC_PL: Pass = ~n;
      CC_VS: Pass = v;
      CC_VC: Pass = ~v;
      CC_HI: Pass = c & ~z;
      CC_LS: Pass = ~c | z;
      CC_GE: Pass = (n == v);
      CC_LT: Pass = (n != v);
      CC_GT: Pass = ~z & (n == v);
      CC_LE: Pass = z | (n != v);
      CC_NV: Pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_condition_unit.sv
// Branch condition resolver with flag-write interlock and stats.
// Ports: Clk/Reset, Flags/FR_Ld, request (Cond_Req, Cond, Target,
// Next_PC), response (Cond_Ack, Taken, Branch_Addr), Busy, counters.
module flag_condition_unit
  import flag_condition_unit_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        Flags,
  input  logic              FR_Ld,
  input  logic              Cond_Req,
  input  logic [3:0]        Cond,
  input  logic [ADDR_W-1:0] Target,
  input  logic [ADDR_W-1:0] Next_PC,
  output logic              Cond_Ack,
  output logic              Taken,
  output logic [ADDR_W-1:0] Branch_Addr,
  output logic              Busy,
  output logic [CNT_W-1:0]  Eval_Cnt,
  output logic [CNT_W-1:0]  Taken_Cnt
);

  state_t            state;
  logic [3:0]        cap_cond;
  logic [ADDR_W-1:0] cap_tgt;
  logic [ADDR_W-1:0] cap_nxt;

  logic              wait_st;
  logic [3:0]        sel_cond;
  logic [ADDR_W-1:0] sel_tgt;
  logic [ADDR_W-1:0] sel_nxt;
  logic              pass;
  logic              ack_now;
  logic              defer;

  assign wait_st = (state == ST_WAIT);
  assign Busy    = wait_st;

  // In WAIT the held request is resolved; otherwise the live one.
  assign sel_cond = wait_st ? cap_cond : Cond;
  assign sel_tgt  = wait_st ? cap_tgt  : Target;
  assign sel_nxt  = wait_st ? cap_nxt  : Next_PC;

  // A request colliding with a flag load is parked for one cycle
  // so it sees the flags after the load has landed.
  assign defer   = ~wait_st & Cond_Req & FR_Ld;
  assign ack_now = wait_st | (Cond_Req & ~FR_Ld);

  flag_condition_unit_cond_eval u_cond_eval (
    .Flags (Flags),
    .Cond  (sel_cond),
    .Pass  (pass)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cap_cond    <= '0;
      cap_tgt     <= '0;
      cap_nxt     <= '0;
      Cond_Ack    <= 1'b0;
      Taken       <= 1'b0;
      Branch_Addr <= '0;
      Eval_Cnt    <= '0;
      Taken_Cnt   <= '0;
    end else begin
      Cond_Ack <= 1'b0;

      unique case (state)
        ST_IDLE, ST_RESP: begin
          if (defer)
            state <= ST_WAIT;
          else if (Cond_Req)
            state <= ST_RESP;
          else
            state <= ST_IDLE;
        end
        ST_WAIT: state <= ST_RESP;
        default: state <= ST_IDLE;
      endcase

      if (defer) begin
        cap_cond <= Cond;
        cap_tgt  <= Target;
        cap_nxt  <= Next_PC;
      end

      if (ack_now) begin
        Cond_Ack    <= 1'b1;
        Taken       <= pass;
        Branch_Addr <= pass ? sel_tgt : sel_nxt;
        if (~&Eval_Cnt)
          Eval_Cnt <= Eval_Cnt + 1'b1;
        if (pass && ~&Taken_Cnt)
          Taken_Cnt <= Taken_Cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_condition_unit.sv
// Self-checking bench for flag_condition_unit.
// Directed table, hand sequences, random and exhaustive sweeps.
module tb_flag_condition_unit;

  logic       Clk;
  logic       Reset;
  logic [3:0] Flags;
  logic       FR_Ld;
  logic       Cond_Req;
  logic [3:0] Cond;
  logic [7:0] Target;
  logic [7:0] Next_PC;
  logic       Cond_Ack;
  logic       Taken;
  logic [7:0] Branch_Addr;
  logic       Busy;
  logic [7:0] Eval_Cnt;
  logic [7:0] Taken_Cnt;

  int n_tests;
  int n_fail;
  int m_eval;
  int m_taken;

  flag_condition_unit #(.ADDR_W(8), .CNT_W(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Flags      (Flags),
    .FR_Ld      (FR_Ld),
    .Cond_Req   (Cond_Req),
    .Cond       (Cond),
    .Target     (Target),
    .Next_PC    (Next_PC),
    .Cond_Ack   (Cond_Ack),
    .Taken      (Taken),
    .Branch_Addr(Branch_Addr),
    .Busy       (Busy),
    .Eval_Cnt   (Eval_Cnt),
    .Taken_Cnt  (Taken_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] flags;
    logic       ld;
    logic [3:0] new_flags;
    logic [3:0] cond;
    logic [7:0] tgt;
    logic [7:0] nxt;
    logic       exp_taken;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  // Reference condition table in terms of named flags.
  function automatic logic ref_taken(input logic [3:0] cc,
                                     input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return 1'b1;
      4'h1: return z;
      4'h2: return !z;
      4'h3: return c;
      4'h4: return !c;
      4'h5: return n;
      4'h6: return !n;
      4'h7: return v;
      4'h8: return !v;
      4'h9: return c && !z;
      4'hA: return !c || z;
      4'hB: return n == v;
      4'hC: return n != v;
      4'hD: return !z && (n == v);
      4'hE: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_ack(input string name, input logic et,
                         input logic [7:0] ea);
    m_eval++;
    if (et) m_taken++;
    chk({name, ".ack"}, int'(Cond_Ack), 1);
    chk({name, ".taken"}, int'(Taken), int'(et));
    chk({name, ".addr"}, int'(Branch_Addr), int'(ea));
    chk({name, ".busy"}, int'(Busy), 0);
    chk({name, ".evcnt"}, int'(Eval_Cnt), sat(m_eval));
    chk({name, ".tkcnt"}, int'(Taken_Cnt), sat(m_taken));
  endtask

  // Issue one request; leaves the DUT in its response cycle.
  task automatic do_req(input string name, input logic [3:0] f,
                        input logic ld, input logic [3:0] nf,
                        input logic [3:0] cc, input logic [7:0] t,
                        input logic [7:0] nx, input logic et,
                        input logic [7:0] ea);
    Flags = f; FR_Ld = ld; Cond_Req = 1'b1;
    Cond = cc; Target = t; Next_PC = nx;
    tick();
    Cond_Req = 1'b0; FR_Ld = 1'b0;
    Cond = ~cc; Target = ~t; Next_PC = ~nx;
    if (ld) begin
      Flags = nf;
      chk({name, ".busy1"}, int'(Busy), 1);
      chk({name, ".noack1"}, int'(Cond_Ack), 0);
      tick();
    end
    chk_ack(name, et, ea);
  endtask

  task automatic chk_reset(input string name);
    chk({name, ".ack"}, int'(Cond_Ack), 0);
    chk({name, ".taken"}, int'(Taken), 0);
    chk({name, ".addr"}, int'(Branch_Addr), 0);
    chk({name, ".busy"}, int'(Busy), 0);
    chk({name, ".evcnt"}, int'(Eval_Cnt), 0);
    chk({name, ".tkcnt"}, int'(Taken_Cnt), 0);
  endtask

  initial begin
    logic [3:0] f, nf, cc;
    logic       ld, et;
    logic [7:0] t, nx;

    n_tests = 0; n_fail = 0; m_eval = 0; m_taken = 0;
    Reset = 1'b1; Flags = '0; FR_Ld = 1'b0; Cond_Req = 1'b0;
    Cond = '0; Target = '0; Next_PC = '0;

    vecs[0] = '{4'b0100, 1'b0, 4'b0000, 4'h1, 8'h40, 8'h11, 1'b1, 8'h40};
    vecs[1] = '{4'b0100, 1'b1, 4'b0000, 4'h1, 8'h40, 8'h11, 1'b0, 8'h11};
    vecs[2] = '{4'b0010, 1'b0, 4'b0000, 4'h9, 8'hA0, 8'hA4, 1'b1, 8'hA0};
    vecs[3] = '{4'b1000, 1'b0, 4'b0000, 4'hC, 8'h33, 8'h34, 1'b1, 8'h33};
    vecs[4] = '{4'b0000, 1'b1, 4'b0110, 4'hD, 8'h55, 8'h56, 1'b0, 8'h56};
    vecs[5] = '{4'b1001, 1'b0, 4'b0000, 4'hB, 8'h77, 8'h78, 1'b1, 8'h77};
    vecs[6] = '{4'b1111, 1'b0, 4'b0000, 4'hF, 8'h88, 8'h89, 1'b0, 8'h89};
    vecs[7] = '{4'b0000, 1'b1, 4'b1000, 4'h6, 8'h12, 8'h13, 1'b0, 8'h13};

    tick(); tick();
    chk_reset("reset");
    Reset = 1'b0;
    tick();
    chk_reset("idle");

    for (int i = 0; i < 8; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].flags, vecs[i].ld,
             vecs[i].new_flags, vecs[i].cond, vecs[i].tgt,
             vecs[i].nxt, vecs[i].exp_taken, vecs[i].exp_addr);
      tick();
      chk($sformatf("vec%0d.ackdrop", i), int'(Cond_Ack), 0);
    end

    // Back-to-back: AL then NV on consecutive cycles.
    Flags = 4'b0000; FR_Ld = 1'b0; Cond_Req = 1'b1;
    Cond = 4'h0; Target = 8'hC0; Next_PC = 8'hC1;
    tick();
    Cond = 4'hF; Target = 8'hD0; Next_PC = 8'hD1;
    chk_ack("b2b0", 1'b1, 8'hC0);
    tick();
    Cond_Req = 1'b0;
    chk_ack("b2b1", 1'b0, 8'hD1);
    tick();
    chk("b2b.idle", int'(Cond_Ack), 0);

    // Reset while the request is parked in WAIT.
    Flags = 4'b0100; FR_Ld = 1'b1; Cond_Req = 1'b1;
    Cond = 4'h0; Target = 8'h5A; Next_PC = 8'h5B;
    tick();
    FR_Ld = 1'b0; Cond_Req = 1'b0;
    chk("rstwait.busy", int'(Busy), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_eval = 0; m_taken = 0;
    chk_reset("rstwait");
    tick();
    chk_reset("rstwait.after");

    // A second request during WAIT must be dropped.
    Flags = 4'b0000; FR_Ld = 1'b1; Cond_Req = 1'b1;
    Cond = 4'h1; Target = 8'h20; Next_PC = 8'h21;
    tick();
    Flags = 4'b0100; FR_Ld = 1'b0;
    Cond = 4'h2; Target = 8'h30; Next_PC = 8'h31;
    chk("reqwait.busy", int'(Busy), 1);
    tick();
    Cond_Req = 1'b0;
    chk_ack("reqwait", 1'b1, 8'h20);
    tick();
    chk("reqwait.noack2", int'(Cond_Ack), 0);
    chk("reqwait.nobusy", int'(Busy), 0);
    tick();
    chk("reqwait.noack3", int'(Cond_Ack), 0);

    // Random requests against the reference model.
    for (int i = 0; i < 120; i++) begin
      f  = 4'($urandom);
      nf = 4'($urandom);
      ld = 1'($urandom_range(0, 1));
      cc = 4'($urandom);
      t  = 8'($urandom);
      nx = 8'($urandom);
      et = ref_taken(cc, ld ? nf : f);
      do_req($sformatf("rnd%0d", i), f, ld, nf, cc, t, nx, et,
             et ? t : nx);
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Exhaustive sweep, back-to-back; pushes counters to saturation.
    for (int c = 0; c < 16; c++) begin
      for (int g = 0; g < 16; g++) begin
        cc = 4'(c);
        f  = 4'(g);
        et = ref_taken(cc, f);
        do_req($sformatf("sw%0d_%0d", c, g), f, 1'b0, 4'b0, cc,
               8'(c * 16 + g), 8'(255 - c * 16 - g), et,
               et ? 8'(c * 16 + g) : 8'(255 - c * 16 - g));
      end
    end
    tick();
    chk("sat.eval", int'(Eval_Cnt), 255);
    chk("sat.taken", int'(Taken_Cnt), sat(m_taken));
    chk("hold.taken", int'(Taken), 0);
    chk("hold.addr", int'(Branch_Addr), 8'h00);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_reset("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
